axi_burst_ram: RTL and testbench

- AXI4 slave RAM model used as the external memory behind the GPGPU AXI master in system simulation.
- Independent write (AW/W/B) and read (AR/R) engines share one byte-addressable word array; supports FIXED/INCR/WRAP bursts, byte strobes and ID echo.

---
 rtl/axi_burst_ram_if.sv | 73 +++++++
 rtl/axi_burst_ram.sv | 332 +++++++++++++++++++++++++++++++++
 tb/tb_axi_burst_ram.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_ram_if.sv
// AXI4 bus bundle between a system master and the axi_burst_ram slave model.
interface axi_burst_ram_if #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
   logic [ID_WIDTH-1:0]   awid;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [7:0]            awlen;
   logic [2:0]            awsize;
   logic [1:0]            awburst;
   logic                  awlock;
   logic [3:0]            awcache;
   logic [2:0]            awprot;
   logic                  awvalid;
   logic                  awready;

   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wlast;
   logic                  wvalid;
   logic                  wready;

   logic [ID_WIDTH-1:0]   bid;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;

   logic [ID_WIDTH-1:0]   arid;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [7:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic                  arlock;
   logic [3:0]            arcache;
   logic [2:0]            arprot;
   logic                  arvalid;
   logic                  arready;

   logic [ID_WIDTH-1:0]   rid;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rlast;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );
endinterface

// File: rtl/axi_burst_ram.sv
// AXI4 slave RAM model with independent write/read burst engines over one word array.
// Define AXI_RAM_RD_PIPE_EN to register the read channel through a 2-entry skid buffer.
module axi_burst_ram #(
   parameter int unsigned DATA_WIDTH          = 64,
   parameter int unsigned ADDR_WIDTH          = 32,
   parameter int unsigned ID_WIDTH            = 4,
   parameter int unsigned STRB_WIDTH          = DATA_WIDTH / 8,
   parameter int unsigned MEM_WORD_ADDR_WIDTH = 16
) (
   input logic               clk,
   input logic               rst,
   axi_burst_ram_if.slave    s_axi
);
   localparam int unsigned WB        = $clog2(STRB_WIDTH);
   localparam int unsigned MEM_DEPTH = 2 ** MEM_WORD_ADDR_WIDTH;

   typedef logic [MEM_WORD_ADDR_WIDTH-1:0] widx_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   function automatic widx_t word_idx(input logic [ADDR_WIDTH-1:0] a);
      return a[WB+MEM_WORD_ADDR_WIDTH-1:WB];
   endfunction

   // WRAP windows are (len+1)*2^size bytes; legal wrap lengths make that a power of two.
   function automatic logic [ADDR_WIDTH-1:0] next_addr(
      input logic [ADDR_WIDTH-1:0] a,
      input logic [7:0]            len,
      input logic [2:0]            size,
      input logic [1:0]            burst
   );
      logic [2:0]            sz;
      logic [ADDR_WIDTH-1:0] step;
      logic [ADDR_WIDTH-1:0] mask;
      logic [ADDR_WIDTH-1:0] inc;
      sz   = (size > 3'(WB)) ? 3'(WB) : size;
      step = ADDR_WIDTH'(1) << sz;
      mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << sz) - ADDR_WIDTH'(1);
      inc  = a + step;
      case (burst)
         2'b00:   return a;
         2'b10:   return (a & ~mask) | (inc & mask);
         default: return inc;
      endcase
   endfunction

   // ---------------- write engine ----------------
   w_state_e              w_state_q, w_state_d;
   logic                  awready_q, awready_d;
   logic                  wready_q, wready_d;
   logic                  bvalid_q, bvalid_d;
   logic [ID_WIDTH-1:0]   bid_q, bid_d;
   logic [ID_WIDTH-1:0]   wid_q, wid_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [7:0]            wlen_q, wlen_d;
   logic [2:0]            wsize_q, wsize_d;
   logic [1:0]            wburst_q, wburst_d;
   logic [7:0]            wcnt_q, wcnt_d;
   logic                  w_hs;

   assign w_hs = wready_q && s_axi.wvalid;

   always_comb begin
      w_state_d = w_state_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      bid_d     = bid_q;
      wid_d     = wid_q;
      waddr_d   = waddr_q;
      wlen_d    = wlen_q;
      wsize_d   = wsize_q;
      wburst_d  = wburst_q;
      wcnt_d    = wcnt_q;
      case (w_state_q)
         W_IDLE: begin
            awready_d = 1'b1;
            if (awready_q && s_axi.awvalid) begin
               wid_d     = s_axi.awid;
               waddr_d   = s_axi.awaddr;
               wlen_d    = s_axi.awlen;
               wsize_d   = s_axi.awsize;
               wburst_d  = s_axi.awburst;
               wcnt_d    = s_axi.awlen;
               awready_d = 1'b0;
               wready_d  = 1'b1;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (w_hs) begin
               waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
               if (wcnt_q == 8'd0) begin
                  wready_d  = 1'b0;
                  bvalid_d  = 1'b1;
                  bid_d     = wid_q;
                  w_state_d = W_RESP;
               end else begin
                  wcnt_d = wcnt_q - 8'd1;
               end
            end
         end
         W_RESP: begin
            if (s_axi.bready) begin
               bvalid_d  = 1'b0;
               awready_d = 1'b1;
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // A beat presented in the reset cycle belongs to the abandoned burst.
   always_ff @(posedge clk) begin
      if (w_hs && !rst) begin
         for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
            if (s_axi.wstrb[b]) mem[word_idx(waddr_q)][8*b +: 8] <= s_axi.wdata[8*b +: 8];
         end
      end
   end

   assign s_axi.awready = awready_q;
   assign s_axi.wready  = wready_q;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bid     = bid_q;
   assign s_axi.bresp   = '0;
   assign s_axi.rresp   = '0;

   // ---------------- read engine ----------------
   r_state_e              r_state_q, r_state_d;
   logic                  arready_q, arready_d;
   logic                  c_valid_q, c_valid_d;
   logic [DATA_WIDTH-1:0] c_data_q, c_data_d;
   logic                  c_last_q, c_last_d;
   logic [ID_WIDTH-1:0]   c_id_q, c_id_d;
   logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
   logic [7:0]            rlen_q, rlen_d;
   logic [2:0]            rsize_q, rsize_d;
   logic [1:0]            rburst_q, rburst_d;
   logic [7:0]            rcnt_q, rcnt_d;
   logic                  core_take;
   widx_t                 rd_idx;
   logic [DATA_WIDTH-1:0] rd_word;

   always_comb begin
      rd_idx  = (r_state_q == R_IDLE) ? word_idx(s_axi.araddr) : word_idx(raddr_q);
      rd_word = mem[rd_idx];
   end

   always_comb begin
      r_state_d = r_state_q;
      arready_d = arready_q;
      c_valid_d = c_valid_q;
      c_data_d  = c_data_q;
      c_last_d  = c_last_q;
      c_id_d    = c_id_q;
      raddr_d   = raddr_q;
      rlen_d    = rlen_q;
      rsize_d   = rsize_q;
      rburst_d  = rburst_q;
      rcnt_d    = rcnt_q;
      case (r_state_q)
         R_IDLE: begin
            arready_d = 1'b1;
            if (arready_q && s_axi.arvalid) begin
               c_id_d    = s_axi.arid;
               c_data_d  = rd_word;
               c_valid_d = 1'b1;
               c_last_d  = (s_axi.arlen == 8'd0);
               raddr_d   = next_addr(s_axi.araddr, s_axi.arlen, s_axi.arsize, s_axi.arburst);
               rlen_d    = s_axi.arlen;
               rsize_d   = s_axi.arsize;
               rburst_d  = s_axi.arburst;
               rcnt_d    = s_axi.arlen;
               arready_d = 1'b0;
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            if (core_take) begin
               if (c_last_q) begin
                  c_valid_d = 1'b0;
                  c_last_d  = 1'b0;
                  arready_d = 1'b1;
                  r_state_d = R_IDLE;
               end else begin
                  c_data_d = rd_word;
                  c_last_d = (rcnt_q == 8'd1);
                  rcnt_d   = rcnt_q - 8'd1;
                  raddr_d  = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bid_q     <= '0;
         wid_q     <= '0;
         waddr_q   <= '0;
         wlen_q    <= '0;
         wsize_q   <= '0;
         wburst_q  <= '0;
         wcnt_q    <= '0;
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         c_valid_q <= 1'b0;
         c_data_q  <= '0;
         c_last_q  <= 1'b0;
         c_id_q    <= '0;
         raddr_q   <= '0;
         rlen_q    <= '0;
         rsize_q   <= '0;
         rburst_q  <= '0;
         rcnt_q    <= '0;
      end else begin
         w_state_q <= w_state_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bid_q     <= bid_d;
         wid_q     <= wid_d;
         waddr_q   <= waddr_d;
         wlen_q    <= wlen_d;
         wsize_q   <= wsize_d;
         wburst_q  <= wburst_d;
         wcnt_q    <= wcnt_d;
         r_state_q <= r_state_d;
         arready_q <= arready_d;
         c_valid_q <= c_valid_d;
         c_data_q  <= c_data_d;
         c_last_q  <= c_last_d;
         c_id_q    <= c_id_d;
         raddr_q   <= raddr_d;
         rlen_q    <= rlen_d;
         rsize_q   <= rsize_d;
         rburst_q  <= rburst_d;
         rcnt_q    <= rcnt_d;
      end
   end

   assign s_axi.arready = arready_q;

`ifdef AXI_RAM_RD_PIPE_EN
   typedef struct packed {
      logic [ID_WIDTH-1:0]   id;
      logic [DATA_WIDTH-1:0] data;
      logic                  last;
   } rbeat_t;

   rbeat_t     f0_q, f0_d, f1_q, f1_d, c_beat;
   logic [1:0] fcnt_q, fcnt_d;
   logic       rvalid_q, rvalid_d;
   logic       pop;

   // Core refill depends only on the registered fill level, so rready never reaches memory.
   assign core_take = c_valid_q && (fcnt_q != 2'd2);

   always_comb begin
      c_beat = {c_id_q, c_data_q, c_last_q};
      pop    = rvalid_q && s_axi.rready;
      f0_d   = f0_q;
      f1_d   = f1_q;
      fcnt_d = fcnt_q;
      case (fcnt_q)
         2'd0: begin
            if (core_take) begin
               f0_d   = c_beat;
               fcnt_d = 2'd1;
            end
         end
         2'd1: begin
            case ({pop, core_take})
               2'b11: f0_d = c_beat;
               2'b01: begin
                  f1_d   = c_beat;
                  fcnt_d = 2'd2;
               end
               2'b10: fcnt_d = 2'd0;
               default: ;
            endcase
         end
         default: begin
            if (pop) begin
               f0_d   = f1_q;
               fcnt_d = 2'd1;
            end
         end
      endcase
      rvalid_d = (fcnt_d != 2'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         f0_q     <= '0;
         f1_q     <= '0;
         fcnt_q   <= '0;
         rvalid_q <= 1'b0;
      end else begin
         f0_q     <= f0_d;
         f1_q     <= f1_d;
         fcnt_q   <= fcnt_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign s_axi.rvalid = rvalid_q;
   assign s_axi.rdata  = f0_q.data;
   assign s_axi.rlast  = f0_q.last;
   assign s_axi.rid    = f0_q.id;
`else
   assign core_take    = c_valid_q && s_axi.rready;
   assign s_axi.rvalid = c_valid_q;
   assign s_axi.rdata  = c_data_q;
   assign s_axi.rlast  = c_last_q;
   assign s_axi.rid    = c_id_q;
`endif

   logic unused_inputs;
   assign unused_inputs = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.wlast,
                            s_axi.arlock, s_axi.arcache, s_axi.arprot};

endmodule

// File: tb/tb_axi_burst_ram.sv
// Scoreboard bench for axi_burst_ram: expected B/R responses queued at issue, checked by monitor.
module tb_axi_burst_ram;
   localparam logic [1:0] FIXED = 2'b00;
   localparam logic [1:0] INCR  = 2'b01;
   localparam logic [1:0] WRAP  = 2'b10;

   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] data;
      logic        last;
   } rbeat_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   axi_burst_ram_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .ID_WIDTH(4)) bus ();

   axi_burst_ram #(
      .DATA_WIDTH(64),
      .ADDR_WIDTH(32),
      .ID_WIDTH(4),
      .MEM_WORD_ADDR_WIDTH(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .s_axi(bus)
   );

   int checks = 0;
   int errors = 0;

   rbeat_t     r_exp_q[$];
   logic [3:0] b_exp_q[$];

   logic [63:0] wd [16];
   logic [7:0]  ws [16];
   logic [63:0] ed [16];
   logic        rready_toggle = 1'b0;

   function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // rready: steady high, or toggling every cycle for backpressure
   initial begin
      bus.rready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rready_toggle) bus.rready = ~bus.rready;
         else bus.rready = 1'b1;
      end
   end

   // Monitor: pops expected responses on each handshake and checks R stability under stall
   initial begin
      rbeat_t held_beat;
      rbeat_t cur;
      rbeat_t e;
      logic   held;
      logic [3:0] eb;
      held = 1'b0;
      held_beat = '0;
      forever begin
         @(negedge clk);
         cur = {bus.rid, bus.rdata, bus.rlast};
         if (held) chk("r_stable", 128'({bus.rvalid, cur}), 128'({1'b1, held_beat}));
         held = bus.rvalid && !bus.rready;
         held_beat = cur;
         if (bus.rvalid && bus.rready) begin
            if (r_exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL r_unexpected: got beat %h expected none", cur);
            end else begin
               e = r_exp_q.pop_front();
               chk("r_beat", 128'({bus.rresp, cur}), 128'({2'b00, e}));
            end
         end
         if (bus.bvalid && bus.bready) begin
            if (b_exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL b_unexpected: got bid %h expected none", bus.bid);
            end else begin
               eb = b_exp_q.pop_front();
               chk("b_resp", 128'({bus.bid, bus.bresp}), 128'({eb, 2'b00}));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic wait_ready(input int sel, input string name);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         case (sel)
            0:       got = bus.awready;
            1:       got = bus.wready;
            default: got = bus.arready;
         endcase
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: ready=0 required=1 within 200 cycles", name);
      end else begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
      bus.awid = id;
      bus.awaddr = addr;
      bus.awlen = len;
      bus.awsize = size;
      bus.awburst = burst;
      bus.awvalid = 1'b1;
      wait_ready(0, "aw");
      bus.awvalid = 1'b0;
   endtask

   task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
      b_exp_q.push_back(id);
      do_aw(id, addr, len, size, burst);
      for (int i = 0; i <= int'(len); i++) begin
         bus.wdata = wd[i];
         bus.wstrb = ws[i];
         bus.wlast = (i == int'(len));
         bus.wvalid = 1'b1;
         wait_ready(1, "w");
      end
      bus.wvalid = 1'b0;
      bus.wlast = 1'b0;
   endtask

   task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
      for (int i = 0; i <= int'(len); i++) r_exp_q.push_back({id, ed[i], i == int'(len)});
      bus.arid = id;
      bus.araddr = addr;
      bus.arlen = len;
      bus.arsize = size;
      bus.arburst = burst;
      bus.arvalid = 1'b1;
      wait_ready(2, "ar");
      bus.arvalid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while ((r_exp_q.size() != 0 || b_exp_q.size() != 0) && n < 300) begin
         @(posedge clk);
         n++;
      end
      chk({name, "_drained"}, 128'(r_exp_q.size() + b_exp_q.size()), 128'(0));
      r_exp_q.delete();
      b_exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
      bus.awlock = 1'b0; bus.awcache = '0; bus.awprot = '0; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
      bus.bready = 1'b1;
      bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
      bus.arlock = 1'b0; bus.arcache = '0; bus.arprot = '0; bus.arvalid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         ws[i] = 8'hFF;
         wd[i] = '0;
         ed[i] = '0;
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("init_reset_outputs", 128'({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid}), 128'(0));
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("init_release_ready", 128'({bus.awready, bus.arready}), 128'(2'b11));

      // Reset in the middle of a write burst: one beat lands, rest abandoned
      do_aw(4'd1, 32'h500, 8'd3, 3'd3, INCR);
      wd[0] = 64'h5555_5555_5555_5555;
      bus.wdata = wd[0];
      bus.wstrb = 8'hFF;
      bus.wvalid = 1'b1;
      wait_ready(1, "w_pre_reset");
      bus.wvalid = 1'b0;
      rst = 1'b1;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         chk("mid_reset_outputs", 128'({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid}), 128'(0));
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_reset_ready", 128'({bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid}), 128'(5'b11000));
      chk("post_reset_ids", 128'({bus.bid, bus.rid, bus.bresp, bus.rresp, bus.rlast, bus.rdata}), 128'(0));

      // INCR write then read back, ID 5
      wd[0] = 64'h1111_1111_1111_1111; wd[1] = 64'h2222_2222_2222_2222;
      wd[2] = 64'h3333_3333_3333_3333; wd[3] = 64'h4444_4444_4444_4444;
      write_burst(4'd5, 32'h100, 8'd3, 3'd3, INCR);
      wait_done("incr_wr");
      for (int i = 0; i < 4; i++) ed[i] = wd[i];
      read_burst(4'd5, 32'h100, 8'd3, 3'd3, INCR);
      wait_done("incr_rd");

      // Byte strobes
      wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
      write_burst(4'd2, 32'h200, 8'd0, 3'd3, INCR);
      wait_done("strb_wr1");
      wd[0] = 64'h0;
      ws[0] = 8'h0F;
      write_burst(4'd2, 32'h200, 8'd0, 3'd3, INCR);
      wait_done("strb_wr2");
      ws[0] = 8'hFF;
      ed[0] = 64'hFFFF_FFFF_0000_0000;
      read_burst(4'd2, 32'h200, 8'd0, 3'd3, INCR);
      wait_done("strb_rd");

      // FIXED burst rewrites one word; neighbour untouched
      wd[0] = 64'hDDDD_0000_DDDD_0000;
      write_burst(4'd3, 32'h308, 8'd0, 3'd3, INCR);
      wait_done("fixed_pre");
      wd[0] = 64'hAAAA_AAAA_AAAA_AAAA; wd[1] = 64'hBBBB_BBBB_BBBB_BBBB; wd[2] = 64'hCCCC_CCCC_CCCC_CCCC;
      write_burst(4'd3, 32'h300, 8'd2, 3'd3, FIXED);
      wait_done("fixed_wr");
      ed[0] = 64'hCCCC_CCCC_CCCC_CCCC; ed[1] = 64'hDDDD_0000_DDDD_0000;
      read_burst(4'd3, 32'h300, 8'd1, 3'd3, INCR);
      wait_done("fixed_rd");

      // WRAP read from the middle of a 32-byte window
      wd[0] = 64'h0400_0400_0400_0400; wd[1] = 64'h0408_0408_0408_0408;
      wd[2] = 64'h0410_0410_0410_0410; wd[3] = 64'h0418_0418_0418_0418;
      write_burst(4'd7, 32'h400, 8'd3, 3'd3, INCR);
      wait_done("wrap_wr");
      ed[0] = wd[3]; ed[1] = wd[0]; ed[2] = wd[1]; ed[3] = wd[2];
      read_burst(4'd7, 32'h418, 8'd3, 3'd3, WRAP);
      wait_done("wrap_rd");

      // 8-beat read under toggling rready
      for (int i = 0; i < 8; i++) wd[i] = {32'hB0B0_B0B0, 32'(i)};
      write_burst(4'd9, 32'h600, 8'd7, 3'd3, INCR);
      wait_done("bp_wr");
      for (int i = 0; i < 8; i++) ed[i] = wd[i];
      rready_toggle = 1'b1;
      read_burst(4'd9, 32'h600, 8'd7, 3'd3, INCR);
      wait_done("bp_rd");
      rready_toggle = 1'b0;

      // B held while bready low; no new AW accepted meanwhile
      bus.bready = 1'b0;
      wd[0] = 64'h7777_7777_7777_7777;
      write_burst(4'd4, 32'h700, 8'd0, 3'd3, INCR);
      begin
         logic seen;
         seen = 1'b0;
         for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = bus.bvalid;
         end
         chk("bvalid_seen", 128'(seen), 128'(1));
      end
      repeat (5) begin
         @(negedge clk);
         chk("b_hold", 128'({bus.bvalid, bus.awready, bus.bid}), 128'({1'b1, 1'b0, 4'd4}));
      end
      @(posedge clk);
      #1;
      bus.bready = 1'b1;
      wait_done("b_stall");

      // Aliasing above memory depth, oversize beat size, and the beat kept across reset
      ed[0] = 64'h1111_1111_1111_1111;
      read_burst(4'd1, 32'h0008_0100, 8'd0, 3'd3, INCR);
      wait_done("alias_rd");
      ed[0] = 64'h1111_1111_1111_1111; ed[1] = 64'h2222_2222_2222_2222;
      read_burst(4'd6, 32'h100, 8'd1, 3'd7, INCR);
      wait_done("bigsize_rd");
      ed[0] = 64'h5555_5555_5555_5555;
      read_burst(4'd0, 32'h500, 8'd0, 3'd3, INCR);
      wait_done("reset_beat_rd");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
